instr_fetch_unit: RTL and testbench

//  Fetch-side initiator for the synchronous instruction memory (registered read, 1-cycle latency,

---
 rtl/mips_pkg.sv | 15 +
 rtl/instr_fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-side constants and FSM state encoding
package mips_pkg;

    localparam int          ADDR_W   = 32;
    localparam int          INSTR_W  = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'h0000_0004;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } ifu_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch initiator: PC, imem address, valid/ready to decode
//
// Owns the PC, issues one address per cycle to a registered-read instruction
// memory, pairs each returned word with its PC and hands it to decode.
// Optional feature macro: IFU_ALIGN_CHECK_EN (misaligned redirect -> sticky fault).
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   fetch_en          1 = keep fetching, 0 = drain the pending word and idle
//   redirect_valid/pc one-cycle redirect pulse and its byte target
//   imem_addr         combinational address to instruction memory
//   imem_instruction  memory read data (one cycle after imem_addr)
//   out_valid/ready   handshake to decode; out_instr/out_pc carry the word
//   fetch_fault       misaligned redirect seen (macro build only, else 0)
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = mips_pkg::ADDR_W,
    parameter int                INSTR_W  = mips_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(mips_pkg::RESET_PC),
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(mips_pkg::PC_STEP)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instruction,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               fetch_fault
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    ifu_state_t        state;
    ifu_state_t        state_n;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] fetch_pc_n;
    logic [ADDR_W-1:0] resp_pc;
    logic [ADDR_W-1:0] resp_pc_n;
    logic              resp_valid;
    logic              resp_valid_n;

    logic              hold;
    logic [ADDR_W-1:0] redir_pc;
    logic              redir_misaligned;
    logic              redir_ok;

    // A presented word that decode refuses: replay its address so the
    // memory re-presents the same data next cycle instead of buffering it.
    assign hold = resp_valid & ~out_ready;

`ifdef IFU_ALIGN_CHECK_EN
    assign redir_pc         = redirect_pc;
    assign redir_misaligned = redirect_valid & (redirect_pc[1:0] != 2'b00);
`else
    // Low bits are dropped so a redirect always lands on a word boundary.
    assign redir_pc         = redirect_pc & WORD_MASK;
    assign redir_misaligned = 1'b0;
`endif

    assign redir_ok = redirect_valid & ~redir_misaligned;

    // A misaligned target is never sent to memory; the address stays at fetch_pc.
    always_comb begin
        if (redir_ok) begin
            imem_addr = redir_pc;
        end else if (hold && !redir_misaligned) begin
            imem_addr = resp_pc;
        end else begin
            imem_addr = fetch_pc;
        end
    end

    assign out_valid = resp_valid & ~redirect_valid & (state != S_FAULT);
    assign out_instr = imem_instruction;
    assign out_pc    = resp_pc;

`ifdef IFU_ALIGN_CHECK_EN
    assign fetch_fault = (state == S_FAULT);
`else
    assign fetch_fault = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            fetch_pc   <= RESET_PC;
            resp_pc    <= RESET_PC;
            resp_valid <= 1'b0;
        end else begin
            state      <= state_n;
            fetch_pc   <= fetch_pc_n;
            resp_pc    <= resp_pc_n;
            resp_valid <= resp_valid_n;
        end
    end

    always_comb begin
        state_n      = state;
        fetch_pc_n   = fetch_pc;
        resp_pc_n    = resp_pc;
        resp_valid_n = resp_valid;

        if (redir_misaligned) begin
            state_n      = S_FAULT;
            resp_valid_n = 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (redir_ok) begin
                        resp_pc_n    = redir_pc;
                        fetch_pc_n   = redir_pc + PC_STEP;
                        resp_valid_n = 1'b1;
                    end else if (hold) begin
                        resp_valid_n = 1'b1;
                    end else if (fetch_en) begin
                        resp_pc_n    = fetch_pc;
                        fetch_pc_n   = fetch_pc + PC_STEP;
                        resp_valid_n = 1'b1;
                    end else begin
                        // Leaving on this edge: the word just accepted was the last one.
                        resp_valid_n = 1'b0;
                    end
                    if (!fetch_en && !hold) begin
                        state_n = S_IDLE;
                    end
                end
                S_IDLE: begin
                    resp_valid_n = hold;
                    if (redir_ok) begin
                        fetch_pc_n   = redir_pc;
                        resp_valid_n = 1'b0;
                    end
                    if (fetch_en) begin
                        state_n = S_RUN;
                    end
                end
                S_FAULT: begin
                    resp_valid_n = 1'b0;
                    if (redir_ok) begin
                        if (fetch_en) begin
                            state_n      = S_RUN;
                            resp_pc_n    = redir_pc;
                            fetch_pc_n   = redir_pc + PC_STEP;
                            resp_valid_n = 1'b1;
                        end else begin
                            state_n    = S_IDLE;
                            fetch_pc_n = redir_pc;
                        end
                    end
                end
                default: begin
                    state_n      = S_IDLE;
                    resp_valid_n = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit with a registered imem model
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instruction = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fetch_fault;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    instr_fetch_unit dut (
        .clk              (clk),
        .reset            (reset),
        .fetch_en         (fetch_en),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem_addr        (imem_addr),
        .imem_instruction (imem_instruction),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instr        (out_instr),
        .out_pc           (out_pc),
        .fetch_fault      (fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h2108_0008;
            32'd4:   return 32'h2129_0008;
            32'd8:   return 32'h1109_0064;
            32'd420: return 32'h0128_5020;
            default: return {16'hC0DE, a[15:0]};
        endcase
    endfunction

    always @(posedge clk) imem_instruction <= mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every accepted word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_xfer: got pc 0x%08h, expected no transfer", out_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("xfer_pc", out_pc, e.pc);
                chk("xfer_instr", out_instr, e.instr);
            end
        end
    end

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        exp_q.push_back('{pc: pc, instr: instr});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pc(input logic [31:0] pc);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (out_valid && out_pc == pc) return;
        end
        total_cnt++;
        $display("FAIL wait_pc: got no valid word, expected out_pc 0x%08h", pc);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fetch_en = 1'b0;
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_fault", {31'b0, fetch_fault}, 32'd0);

        // Sequential fetch, then 3-cycle stall at pc 4, then redirect at pc 8
        do_reset();
        fetch_en = 1'b1;
        push(32'd0, 32'h2108_0008);
        push(32'd4, 32'h2129_0008);
        wait_pc(32'd4);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_pc", out_pc, 32'd4);
            chk("stall_instr", out_instr, 32'h2129_0008);
            chk("stall_addr", imem_addr, 32'd4);
            tick();
        end
        out_ready = 1'b1;
        wait_pc(32'd8);
        chk("seq_instr8", out_instr, 32'h1109_0064);
        redirect_valid = 1'b1;
        redirect_pc = 32'd420;
        push(32'd420, 32'h0128_5020);
        push(32'd424, 32'hC0DE_01A8);
        @(negedge clk);
        chk("redir_drop", {31'b0, out_valid}, 32'd0);
        chk("redir_addr", imem_addr, 32'd420);
        tick();
        redirect_valid = 1'b0;
        wait_pc(32'd424);
        fetch_en = 1'b0;
        repeat (2) tick();
        chk("drain_idle", {31'b0, out_valid}, 32'd0);

        // fetch_en drops while word 4 is stalled: it is still delivered
        do_reset();
        fetch_en = 1'b1;
        push(32'd0, 32'h2108_0008);
        push(32'd4, 32'h2129_0008);
        wait_pc(32'd4);
        out_ready = 1'b0;
        fetch_en = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("stop_hold_valid", {31'b0, out_valid}, 32'd1);
            chk("stop_hold_pc", out_pc, 32'd4);
            tick();
        end
        out_ready = 1'b1;
        tick();
        repeat (3) begin
            @(negedge clk);
            chk("stop_idle", {31'b0, out_valid}, 32'd0);
            tick();
        end

        // Reset asserted mid-stream while pc 8 is presented
        do_reset();
        fetch_en = 1'b1;
        push(32'd0, 32'h2108_0008);
        push(32'd4, 32'h2129_0008);
        wait_pc(32'd8);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_pc", out_pc, 32'd0);
        chk("midrst_addr", imem_addr, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        push(32'd0, 32'h2108_0008);
        push(32'd4, 32'h2129_0008);
        push(32'd8, 32'h1109_0064);
        wait_pc(32'd8);
        fetch_en = 1'b0;
        repeat (2) tick();

        // Misaligned redirect to 0x1A6
        do_reset();
        fetch_en = 1'b1;
        wait_pc(32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_01A6;
`ifdef IFU_ALIGN_CHECK_EN
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fault_flag", {31'b0, fetch_fault}, 32'd1);
            chk("fault_valid", {31'b0, out_valid}, 32'd0);
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_01A4;
        push(32'h1A4, 32'h0128_5020);
        push(32'h1A8, 32'hC0DE_01A8);
        tick();
        redirect_valid = 1'b0;
        chk("fault_clear", {31'b0, fetch_fault}, 32'd0);
`else
        push(32'h1A4, 32'h0128_5020);
        push(32'h1A8, 32'hC0DE_01A8);
        @(negedge clk);
        chk("trunc_addr", imem_addr, 32'h0000_01A4);
        tick();
        redirect_valid = 1'b0;
        chk("nofault", {31'b0, fetch_fault}, 32'd0);
`endif
        wait_pc(32'h1A8);
        fetch_en = 1'b0;
        repeat (4) tick();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
